// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: write ports, read ports and scoreboard control.
// The master side (decode/writeback) drives addresses, data and scoreboard
// commands; the slave side (the register file) returns read data and busy state.
interface register_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2
) ();
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NWR-1:0]        wen;
    logic [NWR*AW-1:0]     wsel;
    logic [NWR*DATA_W-1:0] wdat;
    logic [NRD*AW-1:0]     rsel;
    logic [NRD*DATA_W-1:0] rdat;
    logic [NRD-1:0]        rd_busy;
    logic                  sb_set;
    logic [AW-1:0]         sb_sel;
    logic                  sb_flush;
    logic [NREGS-1:0]      busy_vec;

    modport master (
        output wen, wsel, wdat, rsel, sb_set, sb_sel, sb_flush,
        input  rdat, rd_busy, busy_vec
    );

    modport slave (
        input  wen, wsel, wdat, rsel, sb_set, sb_sel, sb_flush,
        output rdat, rd_busy, busy_vec
    );
endinterface

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with a per-register busy scoreboard.
// - NWR write ports, highest-index port wins on a same-register conflict.
// - NRD combinational read ports returning data and the busy bit.
// - ZERO_REG = 1 hardwires register 0 to zero and never marks it busy.
// - Scoreboard priority per register: flush, then set, then write-clear.
// Optional feature macro: RF_BYPASS_EN (write-through bypass on the read
// ports; same-cycle write data and scoreboard set are forwarded).
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input logic               CLK,
    input logic               nRST,
    register_file_mp_if.slave bus
);
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    // Storage and scoreboard state
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    // Unpacked views of the flattened write-port buses
    logic [AW-1:0]     wsel_s [NWR];
    logic [DATA_W-1:0] wdat_s [NWR];
    logic [NWR-1:0]    wen_eff_s;   // write enable after dropping register-0 writes
    logic [NREGS-1:0]  wr_hit_s;    // registers targeted by an effective write

    // Read-side results before they leave through the interface
    logic [NRD*DATA_W-1:0] rdat_s;
    logic [NRD-1:0]        rd_busy_s;

    // Slice the flattened write buses and qualify each port's enable
    always_comb begin
        for (int k = 0; k < NWR; k++) begin
            wsel_s[k] = bus.wsel[k*AW +: AW];
            wdat_s[k] = bus.wdat[k*DATA_W +: DATA_W];
            if (ZERO_EN && (bus.wsel[k*AW +: AW] == {AW{1'b0}})) begin
                wen_eff_s[k] = 1'b0;
            end else begin
                wen_eff_s[k] = bus.wen[k];
            end
        end
    end

    // Next register contents: ascending port order so the highest port wins
    always_comb begin
        regs_d   = regs_q;
        wr_hit_s = {NREGS{1'b0}};
        for (int k = 0; k < NWR; k++) begin
            if (wen_eff_s[k]) begin
                regs_d[wsel_s[k]]   = wdat_s[k];
                wr_hit_s[wsel_s[k]] = 1'b1;
            end else begin
                wr_hit_s[wsel_s[k]] = wr_hit_s[wsel_s[k]];
            end
        end
    end

    // Next scoreboard: flush beats set, set beats a completing write
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (bus.sb_flush) begin
                busy_d[r] = 1'b0;
            end else if (bus.sb_set && (bus.sb_sel == AW'(r)) && !(ZERO_EN && (r == 0))) begin
                busy_d[r] = 1'b1;
            end else if (wr_hit_s[r]) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
    end

    // Combinational read ports, optionally forwarding same-cycle writes
    always_comb begin
        logic [AW-1:0]     addr_v;
        logic [DATA_W-1:0] data_v;
        logic              busy_v;
        rdat_s    = {(NRD*DATA_W){1'b0}};
        rd_busy_s = {NRD{1'b0}};
        addr_v    = {AW{1'b0}};
        data_v    = {DATA_W{1'b0}};
        busy_v    = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            addr_v = bus.rsel[p*AW +: AW];
            data_v = regs_q[addr_v];
            busy_v = busy_q[addr_v];
`ifdef RF_BYPASS_EN
            // Ascending scan: the last matching port is the conflict winner
            for (int k = 0; k < NWR; k++) begin
                if (wen_eff_s[k] && (wsel_s[k] == addr_v)) begin
                    data_v = wdat_s[k];
                    busy_v = bus.sb_set && (bus.sb_sel == addr_v);
                end else begin
                    data_v = data_v;
                end
            end
`endif
            if (ZERO_EN && (addr_v == {AW{1'b0}})) begin
                data_v = {DATA_W{1'b0}};
                busy_v = 1'b0;
            end else begin
                data_v = data_v;
            end
            rdat_s[p*DATA_W +: DATA_W] = data_v;
            rd_busy_s[p]               = busy_v;
        end
    end

    // State flops: async clear of every register and busy bit
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= {DATA_W{1'b0}};
            end
            busy_q <= {NREGS{1'b0}};
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign bus.rdat     = rdat_s;
    assign bus.rd_busy  = rd_busy_s;
    assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed scenarios followed by
// random traffic, with a spec-level reference model feeding a scoreboard queue.
module tb_register_file_mp;
    localparam int DW    = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int ZR    = 1;
    localparam int AW    = $clog2(NREGS);

    logic clk;
    logic nrst;

    register_file_mp_if #(.DATA_W(DW), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_if ();

    register_file_mp #(
        .DATA_W(DW), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(ZR)
    ) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string                 name;
        logic [NRD*DW-1:0]     rd;
        logic [NRD-1:0]        rb;
        logic [NREGS-1:0]      bv;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    // Reference model: an array of values and an array of busy flags
    logic [DW-1:0]    m_mem [NREGS];
    logic [NREGS-1:0] m_busy;

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
        m_busy = '0;
    endtask

    // Apply one clock edge of architectural behaviour to the model
    task automatic model_edge();
        logic [NREGS-1:0] nb;
        logic [AW-1:0]    a;
        nb = m_busy;
        for (int r = 0; r < NREGS; r++) begin
            if (bus_if.sb_flush) nb[r] = 1'b0;
            else if (bus_if.sb_set && bus_if.sb_sel == AW'(r) && !(ZR != 0 && r == 0)) nb[r] = 1'b1;
            else begin
                for (int k = 0; k < NWR; k++)
                    if (bus_if.wen[k] && bus_if.wsel[k*AW +: AW] == AW'(r)) nb[r] = 1'b0;
            end
        end
        for (int k = 0; k < NWR; k++) begin
            a = bus_if.wsel[k*AW +: AW];
            if (bus_if.wen[k] && !(ZR != 0 && a == '0)) m_mem[a] = bus_if.wdat[k*DW +: DW];
        end
        m_busy = nb;
    endtask

    // Compute what the read ports should show right now and queue it
    task automatic push_expect(input string name);
        exp_t          e;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          b;
        e.name = name;
        e.rd   = '0;
        e.rb   = '0;
        for (int p = 0; p < NRD; p++) begin
            a = bus_if.rsel[p*AW +: AW];
            d = m_mem[a];
            b = m_busy[a];
`ifdef RF_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (bus_if.wen[k] && bus_if.wsel[k*AW +: AW] == a && !(ZR != 0 && a == '0)) begin
                    d = bus_if.wdat[k*DW +: DW];
                    b = bus_if.sb_set && (bus_if.sb_sel == a);
                end
            end
`endif
            if (ZR != 0 && a == '0) begin
                d = '0;
                b = 1'b0;
            end
            e.rd[p*DW +: DW] = d;
            e.rb[p]          = b;
        end
        e.bv = m_busy;
        exp_q.push_back(e);
    endtask

    // Monitor: pop one expectation per negative edge and compare
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (bus_if.rdat !== e.rd)
                $display("FAIL %s rdat: got %h expected %h", e.name, bus_if.rdat, e.rd);
            else passed++;
            total++;
            if (bus_if.rd_busy !== e.rb)
                $display("FAIL %s rd_busy: got %b expected %b", e.name, bus_if.rd_busy, e.rb);
            else passed++;
            total++;
            if (bus_if.busy_vec !== e.bv)
                $display("FAIL %s busy_vec: got %h expected %h", e.name, bus_if.busy_vec, e.bv);
            else passed++;
        end
    end

    task automatic set_idle();
        bus_if.wen      = '0;
        bus_if.wsel     = '0;
        bus_if.wdat     = '0;
        bus_if.rsel     = '0;
        bus_if.sb_set   = 1'b0;
        bus_if.sb_sel   = '0;
        bus_if.sb_flush = 1'b0;
    endtask

    task automatic wr(input int k, input int a, input logic [DW-1:0] d);
        bus_if.wen[k]            = 1'b1;
        bus_if.wsel[k*AW +: AW]  = AW'(a);
        bus_if.wdat[k*DW +: DW]  = d;
    endtask

    task automatic rd(input int p, input int a);
        bus_if.rsel[p*AW +: AW] = AW'(a);
    endtask

    task automatic sb(input int a);
        bus_if.sb_set = 1'b1;
        bus_if.sb_sel = AW'(a);
    endtask

    // One cycle: queue expectation, let the edge happen, advance the model
    task automatic cycle(input string name);
        push_expect(name);
        @(posedge clk);
        if (nrst) model_edge();
        #1;
        set_idle();
    endtask

    task automatic assert_reset();
        nrst = 1'b0;
        model_reset();
    endtask

    initial begin
        nrst = 1'b0;
        model_reset();
        set_idle();
        @(posedge clk);
        #1;
        rd(0, 5); rd(1, 9);
        cycle("reset");
        nrst = 1'b1;

        // Populate, then reset mid-run
        wr(0, 5, 32'hDEADBEEF); sb(12); rd(0, 5);
        cycle("w5");
        rd(0, 5); rd(1, 12);
        cycle("r5");
        assert_reset();
        rd(0, 5); rd(1, 12);
        cycle("mid_reset");
        nrst = 1'b1;
        rd(0, 5);
        cycle("post_reset");

        // Basic write then read
        wr(0, 3, 32'h1234); rd(0, 3);
        cycle("w3_same_cycle");
        rd(0, 3); rd(1, 3);
        cycle("r3");

        // Same-register conflict
        wr(0, 7, 32'hAAAA); wr(1, 7, 32'h5555); rd(0, 7);
        cycle("conflict_same");
        rd(0, 7);
        cycle("conflict_r7");

        // Zero register
        wr(0, 0, 32'hFFFFFFFF); sb(0); rd(0, 0);
        cycle("zero_w");
        rd(0, 0); rd(1, 0);
        cycle("zero_r");

        // Scoreboard set / clear / set-beats-clear
        sb(9); rd(0, 9);
        cycle("sb9_set");
        rd(0, 9); rd(1, 9);
        cycle("sb9_busy");
        wr(1, 9, 32'h99); rd(0, 9);
        cycle("sb9_wr");
        rd(0, 9);
        cycle("sb9_cleared");
        sb(9); wr(0, 9, 32'h999); rd(0, 9);
        cycle("sb9_set_and_wr");
        rd(0, 9);
        cycle("sb9_kept");

        // Flush
        sb(2); cycle("sb2");
        sb(4); cycle("sb4");
        sb(6); rd(1, 6); cycle("sb6");
        bus_if.sb_flush = 1'b1; sb(8); wr(0, 2, 32'h77); rd(0, 2); rd(1, 8);
        cycle("flush");
        rd(0, 2); rd(1, 8);
        cycle("flush_after");

        // Random traffic concentrated on a few registers to provoke conflicts
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NWR; k++)
                if ($urandom_range(0, 2) != 0) wr(k, $urandom_range(0, 7), $urandom);
            for (int p = 0; p < NRD; p++)
                rd(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS - 1) : $urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) sb($urandom_range(0, 7));
            if ($urandom_range(0, 24) == 0) bus_if.sb_flush = 1'b1;
            cycle("random");
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        else passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port register file for the next datapath generation. It provides configurable width, depth, read-port count and write-port count. A per-register scoreboard ("busy" bit) lets the hazard unit stall on registers with an outstanding producer, and register 0 is optionally hardwired to zero. It sits between decode (reads and scoreboard set) and writeback (writes and scoreboard clear).

Parameters:
DATA_W, 32, bits per register
NREGS, 32, number of registers (power of two, >= 2); localparam AW = $clog2(NREGS)
NRD, 2, number of read ports (>= 1)
NWR, 2, number of write ports (>= 1)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
wen  in  NWR  per-port write enable
wsel  in  NWR*AW  per-port write address; port k occupies bits [k*AW +: AW]
wdat  in  NWR*DATA_W  per-port write data; port k occupies bits [k*DATA_W +: DATA_W]
rsel  in  NRD*AW  per-port read address
rdat  out  NRD*DATA_W  per-port read data
rd_busy  out  NRD  scoreboard bit of the register addressed by each read port
sb_set  in  1  mark register sb_sel busy (producer issued)
sb_sel  in  AW  register to mark busy
sb_flush  in  1  clear all busy bits (pipeline flush)
busy_vec  out  NREGS  full scoreboard, registered

Behaviour:
- Reset: the design has one clock, CLK. Reset nRST is asynchronous and active-low. On assertion, all registers go to 0 and all busy bits go to 0, so rdat = 0, rd_busy = 0 and busy_vec = 0 during reset and immediately after release.
- Read: combinational, zero latency. rdat[p] = Reg[rsel[p]] and rd_busy[p] = busy[rsel[p]]. Reads are pure; no read side effects.
- Write: on the rising edge of CLK, for each port k with wen[k] = 1, Reg[wsel[k]] <= wdat[k]. Write latency is 1 cycle; the new value is visible on the read ports after the edge.
- Same-address write conflict: when two or more enabled ports target the same register in one cycle, the highest-index port wins. Loop in ascending port order; the last assignment wins.
- ZERO_REG = 1: writes to address 0 are dropped, reads of address 0 return 0, and busy[0] stays 0 (sb_set to 0 is ignored). With ZERO_REG = 0, register 0 behaves like any other register.
- Scoreboard, per register r, evaluated each edge in priority order:
  1. sb_flush = 1 -> busy[r] <= 0 for all r; it overrides everything else that cycle. Writes still occur.
  2. Otherwise, sb_set = 1 and sb_sel = r -> busy[r] <= 1. Set wins over a same-cycle write clear, because the new producer is younger than the completing one.
  3. Otherwise, any wen[k] = 1 with wsel[k] = r -> busy[r] <= 0.
  4. Otherwise busy[r] holds.
- Out-of-range addresses do not exist, because NREGS is a power of two.
- Reset mid-operation: asynchronous reset clears state immediately. Writes and sets pending in that cycle are lost.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: write-through bypass. If any enabled write port targets rsel[p] in the current cycle (same winner rule, highest index), rdat[p] returns that wdat combinationally and rd_busy[p] = 0, unless a same-cycle sb_set also targets that register, in which case rd_busy[p] = 1. This holds for address 0 only when ZERO_REG = 0.
- Undefined: rdat and rd_busy reflect stored state only, and new data appears on the cycle after the write edge.

Test Plan:
- Reset check: assert nRST mid-run after writing Reg5 = 0xDEADBEEF -> immediately rdat = 0 and busy_vec = 0; after release, reading 5 returns 0.
- Basic write/read: port0 writes Reg3 = 0x1234 -> next cycle rsel0 = 3 gives 0x1234. Without RF_BYPASS_EN, rdat = 0 in the same cycle; with it, rdat = 0x1234 in the same cycle.
- Conflict: port0 writes Reg7 = 0xAAAA and port1 writes Reg7 = 0x5555 in the same cycle -> Reg7 reads 0x5555.
- Zero register (ZERO_REG = 1): write Reg0 = 0xFFFFFFFF and sb_set with sb_sel = 0 -> rdat = 0 and busy_vec[0] = 0.
- Scoreboard: sb_set with sb_sel = 9 -> busy_vec[9] = 1 and rd_busy = 1 when rsel = 9. A write to 9 with no set -> busy clears the next cycle. A write to 9 with a same-cycle sb_set to 9 -> busy stays 1.
- Flush: set busy on registers 2, 4 and 6, then sb_flush = 1 together with sb_set to 8 and a write Reg2 = 0x77 -> busy_vec = 0 and Reg2 = 0x77.
